// File: rtl/bsg_gateway_reset_seq_pkg.sv
// Shared types for the gateway reset sequencer.
package bsg_gateway_reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_MB,
    REL_IO,
    RUN
  } state_e;

endpackage

// File: rtl/bsg_gateway_sync2.sv
// Two-flop synchronizer for single-bit level crossings; clears to 0 on reset.
module bsg_gateway_sync2 (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_r <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_r <= d_i;
      q_o    <= meta_r;
    end
  end

endmodule

// File: rtl/bsg_gateway_reset_seq.sv
// Qualifies clock-generator lock and releases mb, io and core resets in order,
// re-asserting all of them together on lock loss or a software request.
module bsg_gateway_reset_seq
  import bsg_gateway_reset_seq_pkg::*;
#(
  parameter int stable_cycles_p = 1024,
  parameter int step_cycles_p   = 64,
  parameter int count_width_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     locked_i,
  input  logic                     sw_reset_i,
  output logic                     mb_reset_o,
  output logic                     io_reset_o,
  output logic                     core_reset_o,
  output logic                     ready_o,
  output logic [count_width_p-1:0] lock_loss_count_o
);

  localparam int max_cycles_lp = (stable_cycles_p > step_cycles_p) ? stable_cycles_p : step_cycles_p;
  localparam int cnt_width_lp  = $clog2(max_cycles_lp) + 1;

  localparam logic [cnt_width_lp-1:0] stable_load_lp = cnt_width_lp'(stable_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] step_load_lp   = cnt_width_lp'(step_cycles_p - 1);

  function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] v);
    return (&v) ? v : v + count_width_p'(1);
  endfunction

  logic locked_s;

  bsg_gateway_sync2 lock_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .d_i       (locked_i),
    .q_o       (locked_s)
  );

  state_e                   state_r, state_n;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
  logic                     mb_n, io_n, core_n, ready_n;
  logic [count_width_p-1:0] loss_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r           <= WAIT_LOCK;
      cnt_r             <= '0;
      mb_reset_o        <= 1'b1;
      io_reset_o        <= 1'b1;
      core_reset_o      <= 1'b1;
      ready_o           <= 1'b0;
      lock_loss_count_o <= '0;
    end else begin
      state_r           <= state_n;
      cnt_r             <= cnt_n;
      mb_reset_o        <= mb_n;
      io_reset_o        <= io_n;
      core_reset_o      <= core_n;
      ready_o           <= ready_n;
      lock_loss_count_o <= loss_n;
    end
  end

  // Outputs are computed here as next values so every port comes straight from a flop.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    mb_n    = mb_reset_o;
    io_n    = io_reset_o;
    core_n  = core_reset_o;
    ready_n = ready_o;
    loss_n  = lock_loss_count_o;

    if (state_r != WAIT_LOCK && !locked_s) begin
      state_n = WAIT_LOCK;
      mb_n    = 1'b1;
      io_n    = 1'b1;
      core_n  = 1'b1;
      ready_n = 1'b0;
      loss_n  = sat_inc(lock_loss_count_o);
    end else if (state_r != WAIT_LOCK && sw_reset_i) begin
      state_n = STABLE;
      cnt_n   = stable_load_lp;
      mb_n    = 1'b1;
      io_n    = 1'b1;
      core_n  = 1'b1;
      ready_n = 1'b0;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          mb_n    = 1'b1;
          io_n    = 1'b1;
          core_n  = 1'b1;
          ready_n = 1'b0;
          if (locked_s) begin
            state_n = STABLE;
            cnt_n   = stable_load_lp;
          end
        end
        STABLE: begin
          if (cnt_r == '0) begin
            state_n = REL_MB;
            cnt_n   = step_load_lp;
            mb_n    = 1'b0;
          end else begin
            cnt_n = cnt_r - cnt_width_lp'(1);
          end
        end
        REL_MB: begin
          if (cnt_r == '0) begin
            state_n = REL_IO;
            cnt_n   = step_load_lp;
            io_n    = 1'b0;
          end else begin
            cnt_n = cnt_r - cnt_width_lp'(1);
          end
        end
        REL_IO: begin
          if (cnt_r == '0) begin
            state_n = RUN;
            core_n  = 1'b0;
            ready_n = 1'b1;
          end else begin
            cnt_n = cnt_r - cnt_width_lp'(1);
          end
        end
        RUN: begin
          state_n = RUN;
        end
        default: begin
          state_n = WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Bench for bsg_gateway_reset_seq: directed vector tables plus randomized lock/sw traffic.
module tb_bsg_gateway_reset_seq;

  localparam int S = 8;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked_i = 1'b0;
  logic       sw_reset_i = 1'b0;
  logic       mb_reset_o, io_reset_o, core_reset_o, ready_o;
  logic [1:0] lock_loss_count_o;

  bsg_gateway_reset_seq #(
    .stable_cycles_p (S),
    .step_cycles_p   (T),
    .count_width_p   (2)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .locked_i          (locked_i),
    .sw_reset_i        (sw_reset_i),
    .mb_reset_o        (mb_reset_o),
    .io_reset_o        (io_reset_o),
    .core_reset_o      (core_reset_o),
    .ready_o           (ready_o),
    .lock_loss_count_o (lock_loss_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sc       = -1;

  // Reference model: the sequence is described by the edge t0 at which it
  // (re)started; each domain is released a fixed number of edges after t0.
  int   edge_n = 0;
  logic [1:0] hist;
  logic m_run;
  int   t0;
  int   m_cnt;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist  <= 2'b00;
      m_run <= 1'b0;
      t0    <= 0;
      m_cnt <= 0;
    end else begin
      hist <= {hist[0], locked_i};
      if (!m_run) begin
        if (hist[1]) begin
          m_run <= 1'b1;
          t0    <= edge_n + 1;
        end
      end else if (!hist[1]) begin
        m_run <= 1'b0;
        m_cnt <= (m_cnt >= 3) ? 3 : m_cnt + 1;
      end else if (sw_reset_i) begin
        t0 <= edge_n + 1;
      end
    end
  end

  function automatic logic [3:0] model_outs();
    logic mb, io, core;
    if (!m_run) return 4'b1110;
    mb   = (edge_n < t0 + S);
    io   = (edge_n < t0 + S + T);
    core = (edge_n < t0 + S + 2 * T);
    return {mb, io, core, !core};
  endfunction

  function automatic logic [3:0] outs();
    return {mb_reset_o, io_reset_o, core_reset_o, ready_o};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (scenario edge %0d)", name, act, exp, sc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sc++;
    sw_reset_i = 1'b0;
    check("model_outs", int'(outs()), int'(model_outs()));
    check("model_count", int'(lock_loss_count_o), m_cnt);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    locked_i   = 1'b0;
    sw_reset_i = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outs", int'(outs()), 4'b1110);
    check("reset_count", int'(lock_loss_count_o), 0);
    reset_n = 1'b1;
    sc = -1;
  endtask

  typedef struct {
    int         k;
    bit         lk;
    bit         sw;
    logic [3:0] exp;
    int         cnt;
  } vec_t;

  vec_t tab[$];

  task automatic run_table(input string name);
    for (int i = 0; i < tab.size(); i++) begin
      while (sc < tab[i].k) step();
      check({name, "_outs"}, int'(outs()), int'(tab[i].exp));
      check({name, "_count"}, int'(lock_loss_count_o), tab[i].cnt);
      locked_i   = tab[i].lk;
      sw_reset_i = tab[i].sw;
    end
    tab.delete();
  endtask

  initial begin
    // Power-up, lock drop in RUN, relock, sw reset in RUN, sw+loss collision, sw in WAIT_LOCK.
    do_reset();
    locked_i = 1'b1;
    tab.push_back('{9,   1'b1, 1'b0, 4'b1110, 0});
    tab.push_back('{10,  1'b1, 1'b0, 4'b0110, 0});
    tab.push_back('{13,  1'b1, 1'b0, 4'b0110, 0});
    tab.push_back('{14,  1'b1, 1'b0, 4'b0010, 0});
    tab.push_back('{17,  1'b1, 1'b0, 4'b0010, 0});
    tab.push_back('{18,  1'b1, 1'b0, 4'b0001, 0});
    tab.push_back('{29,  1'b0, 1'b0, 4'b0001, 0});
    tab.push_back('{31,  1'b0, 1'b0, 4'b0001, 0});
    tab.push_back('{32,  1'b0, 1'b0, 4'b1110, 1});
    tab.push_back('{39,  1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{49,  1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{50,  1'b1, 1'b0, 4'b0110, 1});
    tab.push_back('{70,  1'b1, 1'b1, 4'b0001, 1});
    tab.push_back('{71,  1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{78,  1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{79,  1'b1, 1'b0, 4'b0110, 1});
    tab.push_back('{87,  1'b1, 1'b0, 4'b0001, 1});
    tab.push_back('{89,  1'b0, 1'b0, 4'b0001, 1});
    tab.push_back('{91,  1'b0, 1'b1, 4'b0001, 1});
    tab.push_back('{92,  1'b0, 1'b0, 4'b1110, 2});
    tab.push_back('{95,  1'b1, 1'b1, 4'b1110, 2});
    tab.push_back('{97,  1'b1, 1'b0, 4'b1110, 2});
    tab.push_back('{105, 1'b1, 1'b0, 4'b1110, 2});
    tab.push_back('{106, 1'b1, 1'b0, 4'b0110, 2});
    run_table("seq");

    // Single-cycle lock glitch while in STABLE.
    do_reset();
    locked_i = 1'b1;
    tab.push_back('{4,  1'b0, 1'b0, 4'b1110, 0});
    tab.push_back('{5,  1'b1, 1'b0, 4'b1110, 0});
    tab.push_back('{7,  1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{10, 1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{15, 1'b1, 1'b0, 4'b1110, 1});
    tab.push_back('{16, 1'b1, 1'b0, 4'b0110, 1});
    run_table("glitch");

    // Five lock losses against a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      locked_i = 1'b1;
      repeat (6) step();
      locked_i = 1'b0;
      repeat (4) step();
      check("sat_count", int'(lock_loss_count_o), (i + 1 > 3) ? 3 : i + 1);
    end

    // Async reset while in REL_IO clears everything without waiting for a clock.
    locked_i = 1'b1;
    repeat (15) step();
    check("relio_outs", int'(outs()), 4'b0010);
    check("relio_count", int'(lock_loss_count_o), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_outs", int'(outs()), 4'b1110);
    check("async_count", int'(lock_loss_count_o), 0);
    reset_n = 1'b1;
    sc = -1;
    repeat (10) step();
    check("restart_pre", int'(outs()), 4'b1110);
    step();
    check("restart_mb", int'(outs()), 4'b0110);

    // Randomized lock and software-reset traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) locked_i = ~locked_i;
      sw_reset_i = ($urandom_range(0, 29) == 0);
      step();
      if ($urandom_range(0, 499) == 0) begin
        locked_i = 1'b1;
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
